// File: rtl/apb_arbiter_pkg.sv
// apb_arbiter_pkg: shared FSM state codes, requester id type and timeout counter width helper
package apb_arbiter_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;
  typedef logic req_id_t;
  function automatic int tmo_w(input int n);
    return n < 1 ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: combinational two-way round-robin picker favouring the requester not granted last
module apb_rr_pick
  import apb_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output req_id_t    gnt_id,
  output logic       gnt_vld
);
  always_comb begin
    gnt_vld = |req;
    gnt_id  = &req ? ~last : req[1];
  end
endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: shares one downstream APB completer between two requesters, round-robin, with stall timeout
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] apbReq0_paddr,
  input  logic              apbReq0_psel,
  input  logic              apbReq0_penable,
  input  logic              apbReq0_pwrite,
  input  logic [DATA_W-1:0] apbReq0_pwdata,
  output logic              apbReq0_pready,
  output logic [DATA_W-1:0] apbReq0_prdata,
  output logic              apbReq0_pslverr,
  input  logic [ADDR_W-1:0] apbReq1_paddr,
  input  logic              apbReq1_psel,
  input  logic              apbReq1_penable,
  input  logic              apbReq1_pwrite,
  input  logic [DATA_W-1:0] apbReq1_pwdata,
  output logic              apbReq1_pready,
  output logic [DATA_W-1:0] apbReq1_prdata,
  output logic              apbReq1_pslverr,
  output logic [ADDR_W-1:0] apbOut_paddr,
  output logic              apbOut_psel,
  output logic              apbOut_penable,
  output logic              apbOut_pwrite,
  output logic [DATA_W-1:0] apbOut_pwdata,
  input  logic              apbOut_pready,
  input  logic              apbOut_pslverr,
  input  logic [DATA_W-1:0] apbOut_prdata,
  output logic              timeout_evt,
  output logic              busy
);
  localparam int CW = tmo_w(TIMEOUT_CYCLES);
  logic [1:0]        state;
  req_id_t           last, gid, gnt_id;
  logic              gnt_vld, tmo_hit, done, rsp, rerr;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] rdata;
  apb_rr_pick u_pick (
    .req     ({apbReq1_psel, apbReq0_psel}),
    .last    (last),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );
  always_comb begin
    tmo_hit = (TIMEOUT_CYCLES != 0) && state == ST_ACCESS && !apbOut_pready
              && cnt == CW'(TIMEOUT_CYCLES - 1);
    done    = state == ST_ACCESS && (apbOut_pready || tmo_hit);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      last           <= 1'b1;
      gid            <= 1'b0;
      cnt            <= '0;
      apbOut_paddr   <= '0;
      apbOut_psel    <= 1'b0;
      apbOut_penable <= 1'b0;
      apbOut_pwrite  <= 1'b0;
      apbOut_pwdata  <= '0;
      rsp            <= 1'b0;
      rdata          <= '0;
      rerr           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (gnt_vld) begin
          gid           <= gnt_id;
          last          <= gnt_id;
          apbOut_paddr  <= gnt_id ? apbReq1_paddr : apbReq0_paddr;
          apbOut_pwrite <= gnt_id ? apbReq1_pwrite : apbReq0_pwrite;
          apbOut_pwdata <= gnt_id ? apbReq1_pwdata : apbReq0_pwdata;
          apbOut_psel   <= 1'b1;
          state         <= ST_SETUP;
        end
        ST_SETUP: begin
          apbOut_penable <= 1'b1;
          cnt            <= '0;
          state          <= ST_ACCESS;
        end
        ST_ACCESS: if (done) begin
          apbOut_psel    <= 1'b0;
          apbOut_penable <= 1'b0;
          rdata          <= apbOut_pready ? apbOut_prdata : '0;
          rerr           <= apbOut_pready ? apbOut_pslverr : 1'b1;
          rsp            <= 1'b1;
          state          <= ST_RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: begin
          rsp   <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
  always_comb begin
    apbReq0_pready  = rsp & ~gid;
    apbReq1_pready  = rsp & gid;
    apbReq0_prdata  = apbReq0_pready ? rdata : '0;
    apbReq1_prdata  = apbReq1_pready ? rdata : '0;
    apbReq0_pslverr = apbReq0_pready & rerr;
    apbReq1_pslverr = apbReq1_pready & rerr;
    timeout_evt     = tmo_hit;
    busy            = state != ST_IDLE;
  end
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: randomized self-checking bench for apb_arbiter against a transaction-level model
module tb_apb_arbiter;
  localparam int TO = 16;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] apbReq0_paddr, apbReq1_paddr, apbReq0_pwdata, apbReq1_pwdata;
  logic apbReq0_psel, apbReq1_psel, apbReq0_penable, apbReq1_penable, apbReq0_pwrite, apbReq1_pwrite;
  logic apbReq0_pready, apbReq1_pready, apbReq0_pslverr, apbReq1_pslverr;
  logic [31:0] apbReq0_prdata, apbReq1_prdata;
  logic [31:0] apbOut_paddr, apbOut_pwdata, apbOut_prdata;
  logic apbOut_psel, apbOut_penable, apbOut_pwrite, apbOut_pready, apbOut_pslverr;
  logic timeout_evt, busy;
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } txn_t;
  txn_t t[2];
  logic pend[2];
  logic mlast;
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .apbReq0_paddr(apbReq0_paddr), .apbReq0_psel(apbReq0_psel), .apbReq0_penable(apbReq0_penable),
    .apbReq0_pwrite(apbReq0_pwrite), .apbReq0_pwdata(apbReq0_pwdata), .apbReq0_pready(apbReq0_pready),
    .apbReq0_prdata(apbReq0_prdata), .apbReq0_pslverr(apbReq0_pslverr),
    .apbReq1_paddr(apbReq1_paddr), .apbReq1_psel(apbReq1_psel), .apbReq1_penable(apbReq1_penable),
    .apbReq1_pwrite(apbReq1_pwrite), .apbReq1_pwdata(apbReq1_pwdata), .apbReq1_pready(apbReq1_pready),
    .apbReq1_prdata(apbReq1_prdata), .apbReq1_pslverr(apbReq1_pslverr),
    .apbOut_paddr(apbOut_paddr), .apbOut_psel(apbOut_psel), .apbOut_penable(apbOut_penable),
    .apbOut_pwrite(apbOut_pwrite), .apbOut_pwdata(apbOut_pwdata), .apbOut_pready(apbOut_pready),
    .apbOut_pslverr(apbOut_pslverr), .apbOut_prdata(apbOut_prdata),
    .timeout_evt(timeout_evt), .busy(busy)
  );
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic txn_t rand_txn(input logic id);
    txn_t x;
    logic [31:0] r;
    int sel;
    r = $urandom();
    x.addr  = {r[31:1], id};
    x.wr    = 1'($urandom_range(0, 1));
    x.wdata = $urandom();
    x.rdata = $urandom();
    x.err   = $urandom_range(0, 7) == 0;
    sel     = $urandom_range(0, 9);
    x.waits = sel == 0 ? TO : sel == 1 ? TO - 1 : $urandom_range(0, 3);
    return x;
  endfunction
  task automatic drive_reqs();
    apbReq0_psel    = pend[0];
    apbReq0_penable = pend[0] & 1'($urandom_range(0, 1));
    apbReq0_paddr   = t[0].addr;
    apbReq0_pwrite  = t[0].wr;
    apbReq0_pwdata  = t[0].wdata;
    apbReq1_psel    = pend[1];
    apbReq1_penable = pend[1] & 1'($urandom_range(0, 1));
    apbReq1_paddr   = t[1].addr;
    apbReq1_pwrite  = t[1].wr;
    apbReq1_pwdata  = t[1].wdata;
  endtask
  task automatic run_xfer(input int r, input bit do_rst);
    logic g;
    logic to;
    logic [31:0] a;
    drive_reqs();
    check("idle_busy", busy, 0);
    check("idle_bus", {apbOut_psel, apbOut_penable}, 0);
    check("idle_rdy", {apbReq0_pready, apbReq1_pready}, 0);
    g = (pend[0] && pend[1]) ? ~mlast : pend[1];
    mlast = g;
    if (do_rst || r == 5) t[g].waits = TO;
    if (r == 6) t[g].waits = TO - 1;
    if (r == 7) begin t[g].waits = 0; t[g].err = 1'b1; end
    a = t[g].addr;
    tick();
    check("setup_ctl", {apbOut_psel, apbOut_penable, busy}, 3'b101);
    check("setup_addr", apbOut_paddr, a);
    check("setup_wr", {apbOut_pwrite, apbOut_pwdata}, {t[g].wr, t[g].wdata});
    tick();
    if (g) apbReq1_paddr = ~a; else apbReq0_paddr = ~a;
    for (int k = 1; k <= TO; k++) begin
      apbOut_pready  = k == t[g].waits + 1;
      apbOut_prdata  = t[g].rdata;
      apbOut_pslverr = t[g].err;
      #1;
      check("acc_ctl", {apbOut_psel, apbOut_penable}, 2'b11);
      check("acc_addr", apbOut_paddr, a);
      check("acc_tmo", timeout_evt, k == TO && t[g].waits >= TO);
      check("acc_rdy", {apbReq0_pready, apbReq1_pready}, 0);
      if (do_rst && k == 2) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apbOut_pready = 1'b0;
        check("rst_bus", {apbOut_paddr, apbOut_pwdata, apbOut_psel, apbOut_penable, apbOut_pwrite, busy, timeout_evt}, 0);
        check("rst_req", {apbReq0_prdata, apbReq1_prdata, apbReq0_pready, apbReq1_pready, apbReq0_pslverr, apbReq1_pslverr}, 0);
        mlast = 1'b1;
        return;
      end
      if (apbOut_pready || k == TO) break;
      tick();
    end
    to = t[g].waits >= TO;
    tick();
    apbOut_pready = 1'b0;
    drive_reqs();
    check("resp_ctl", {apbOut_psel, apbOut_penable, timeout_evt, busy}, 4'b0001);
    check("resp_rdy", {apbReq1_pready, apbReq0_pready}, g ? 2'b10 : 2'b01);
    check("resp_data", g ? apbReq1_prdata : apbReq0_prdata, to ? 32'h0 : t[g].rdata);
    check("resp_err", g ? apbReq1_pslverr : apbReq0_pslverr, to ? 1'b1 : t[g].err);
    check("resp_other", g ? {apbReq0_prdata, apbReq0_pslverr} : {apbReq1_prdata, apbReq1_pslverr}, 0);
    tick();
    pend[g] = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    t[0] = rand_txn(1'b0);
    t[1] = rand_txn(1'b1);
    drive_reqs();
    apbOut_pready = 1'b0;
    apbOut_pslverr = 1'b0;
    apbOut_prdata = '0;
    tick();
    tick();
    check("reset_bus", {apbOut_paddr, apbOut_pwdata, apbOut_psel, apbOut_penable, apbOut_pwrite, busy, timeout_evt}, 0);
    check("reset_req", {apbReq0_prdata, apbReq1_prdata, apbReq0_pready, apbReq1_pready, apbReq0_pslverr, apbReq1_pslverr}, 0);
    rst = 1'b0;
    mlast = 1'b1;
    t[0].addr = 32'h0000_1000;
    t[0].wr = 1'b0;
    t[0].rdata = 32'hDEAD_BEEF;
    t[0].err = 1'b0;
    t[0].waits = 0;
    t[1].wr = 1'b0;
    pend[0] = 1'b1;
    pend[1] = 1'b1;
    for (int r = 0; r < 70; r++) begin
      run_xfer(r, r == 40);
      if (r == 40) begin
        t[0] = rand_txn(1'b0);
        t[1] = rand_txn(1'b1);
        pend[0] = 1'b1;
        pend[1] = 1'b1;
      end else begin
        for (int i = 0; i < 2; i++)
          if (!pend[i] && (r < 4 || $urandom_range(0, 2) != 0)) begin
            t[i] = rand_txn(1'(i));
            pend[i] = 1'b1;
          end
        if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1'b1;
        if (r == 0) begin
          t[0].wr = 1'b1;
          t[0].wdata = 32'h5A5A_5A5A;
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Two-requester APB arbiter: shares the single APB completer port of the `apbDecode` register bus between two APB requesters, such as a host bridge and a debug/DMA requester. Each requester sees a standard APB completer and is held in wait states until its transfer finishes downstream. The block forwards one transfer at a time, grants round-robin, and returns an error response if the downstream completer stalls past a programmable cycle limit.

## Interface
Parameters:
- ADDR_W, 32, address width (matches `apbAddrSt`)
- DATA_W, 32, data width (matches `apbDataSt`)
- TIMEOUT_CYCLES, 16, ACCESS cycles without downstream `pready` before the transfer is aborted; 0 disables the timeout

Ports:
- clk  input  1  single clock; all logic rising-edge
- rst  input  1  synchronous, active-high reset
- apbReq0_paddr / apbReq1_paddr  input  ADDR_W  requester address
- apbReq0_psel / apbReq1_psel  input  1  requester select (= request)
- apbReq0_penable / apbReq1_penable  input  1  requester access phase
- apbReq0_pwrite / apbReq1_pwrite  input  1  requester write
- apbReq0_pwdata / apbReq1_pwdata  input  DATA_W  requester write data
- apbReq0_pready / apbReq1_pready  output  1  completion to requester
- apbReq0_prdata / apbReq1_prdata  output  DATA_W  read data to requester
- apbReq0_pslverr / apbReq1_pslverr  output  1  error to requester
- apbOut_paddr  output  ADDR_W  downstream address; connects to `apbDecode` `apbReg`
- apbOut_psel, apbOut_penable, apbOut_pwrite  output  1  downstream controls
- apbOut_pwdata  output  DATA_W  downstream write data
- apbOut_pready, apbOut_pslverr  input  1  downstream response
- apbOut_prdata  input  DATA_W  downstream read data
- timeout_evt  output  1  one-cycle pulse when a transfer is aborted by timeout
- busy  output  1  high in any state other than IDLE

## Operation
- FSM states and transitions:
  - IDLE: if any `psel` is high, pick a grant, latch that requester's paddr/pwrite/pwdata, go to SETUP. Otherwise stay in IDLE.
  - SETUP: one cycle; go to ACCESS.
  - ACCESS: on `apbOut_pready`, or on timeout, go to RESP.
  - RESP: one cycle; go to IDLE.
- A request is `psel` high, whatever the level of `penable`. A waiting requester may already have raised `penable`.
- Round-robin grant: the `last` pointer holds the ID of the last requester granted.
  - With one requester active, it is granted.
  - With both active, the requester ≠ `last` is granted.
  - `last` updates on every grant. Reset value `last` = 1, so req0 wins the first tie.
- Downstream bus: registered outputs driven from the latched values.
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
  - IDLE and RESP: psel=0, penable=0.
  - paddr/pwrite/pwdata hold their values from SETUP through ACCESS.
- Completion: in ACCESS, when `apbOut_pready`=1, capture prdata and pslverr.
- Timeout: the counter clears in SETUP and increments each ACCESS cycle with `pready`=0. When it reaches TIMEOUT_CYCLES:
  - the abort takes effect in that cycle: captured prdata=0, pslverr=1, `timeout_evt`=1 for 1 cycle;
  - the downstream psel drops on the next cycle;
  - counter width is $clog2(TIMEOUT_CYCLES+1).
  - A `pready` that arrives in the same cycle as the limit wins: normal completion, no timeout.
- Response: in RESP, only the granted requester's `pready`=1, with the captured prdata/pslverr. All requester outputs are 0 in every other cycle.
- Requesters must hold psel/paddr/pwrite/pwdata stable until their `pready`. A change in a requester's signals after the latch has no effect on the transfer in flight.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0; `last`=1.
- Reset asserted mid-transfer: the next edge returns to IDLE with all outputs 0. No response is given to the requester.
- Latency, requester `psel` sampled at edge N:
  - downstream SETUP in cycle N+1;
  - ACCESS in cycle N+2;
  - with zero downstream waits, requester `pready` in N+3.
  - Each downstream wait state adds 1 cycle.
- Throughput: at least 4 cycles per transfer. No downstream back-to-back; IDLE always separates transfers.
- Back-to-back requester: a new SETUP in the cycle after its `pready` is seen in IDLE and arbitrated normally.
- Simultaneous first requests: req0 granted, then req1. The transfers alternate while both keep requesting.

## Structure
- `apb_arbiter_package`:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - requester ID typedef (1 bit);
  - timeout counter width constant.
- Address and data types reuse `apbAddrSt`/`apbDataSt` from the existing APB package.
- Sub-module `apb_rr_pick`: combinational 2-way round-robin picker, inputs req[1:0] and last, outputs gnt_id and gnt_vld. It is kept separate so it can be widened to N requesters later.
- Verilator wrapper generated as for the other blocks, with apb_if dst×2 and src×1.

## Test plan
- Single read: req0 reads 0x0000_1000, completer returns 0xDEAD_BEEF with 0 waits → apbOut SETUP at N+1, ACCESS at N+2; apbReq0_pready=1 with prdata 0xDEAD_BEEF at N+3; apbReq1_pready stays 0.
- Contention: both request at the same edge, req0 writes 0x5A5A_5A5A, req1 reads → req0's transfer first, then req1's; `last`=1 at the end. Both keep requesting for 4 transfers → order 0,1,0,1.
- Wait states: completer holds pready low for 3 cycles → penable high for 4 cycles; requester pready exactly 1 cycle after completion; paddr stable throughout.
- Timeout: TIMEOUT_CYCLES=16, completer never responds → after 16 ACCESS cycles timeout_evt pulses, requester gets pready=1, pslverr=1, prdata=0, and the arbiter returns to IDLE. The same setup with pready arriving on cycle 16 gives normal completion and no timeout_evt.
- Slave error: completer returns pslverr=1 with no waits → requester sees pslverr=1 and timeout_evt stays 0.
- Reset mid-ACCESS: assert rst for 1 cycle during ACCESS → the next cycle all outputs are 0 and state is IDLE. A fresh req1 then completes normally, with req0 preferred on a tie.
